// File: rtl/pkt_modport_if.sv
// Monitored packet-stream bus (no backpressure): the source drives it as master,
// and the byte counter observes it as slave.
interface pkt_modport_if #(
  parameter int D_WIDTH     = 64,
  parameter int EMPTY_WIDTH = 3
);
  logic [D_WIDTH-1:0]     data;
  logic                   sop;
  logic                   eop;
  logic [EMPTY_WIDTH-1:0] empty;
  logic                   val;
  logic [31:0]            flow_num;

  modport master (output data, sop, eop, empty, val, flow_num);
  modport slave  (input  data, sop, eop, empty, val, flow_num);
endinterface

// File: rtl/pkt_modport.sv
// Per-flow L1 byte counters (payload plus 24 bytes of IFG/preamble/CRC per packet), a byte total and a cycle counter.
// Macro PKT_MODPORT_SAT_EN makes the counters saturate; without it they wrap.
module pkt_modport #(
  parameter int D_WIDTH     = 64,
  parameter int EMPTY_WIDTH = 3,
  parameter int FLOW_CNT    = 16,
  parameter int CNT_WIDTH   = 64,
  localparam int FLOW_W     = (FLOW_CNT > 1) ? $clog2(FLOW_CNT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  pkt_modport_if.slave         pkt,
  input  logic                 clr,
  input  logic [FLOW_W-1:0]    rd_flow,
  output logic [CNT_WIDTH-1:0] rd_bytes,
  output logic [CNT_WIDTH-1:0] tick_cnt,
  output logic [CNT_WIDTH-1:0] total_bytes
);

  localparam int BEAT_BYTES = D_WIDTH / 8;
  localparam int AW = ((CNT_WIDTH > 32) ? CNT_WIDTH : 32) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // The addition is one bit wider than either operand, so the carry-out shows the overflow.
  function automatic logic [CNT_WIDTH-1:0] cnt_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [31:0] b);
    logic [AW-1:0] s;
    s = AW'(a) + AW'(b);
`ifdef PKT_MODPORT_SAT_EN
    if (s > AW'(CNT_MAX)) return CNT_MAX;
`endif
    return s[CNT_WIDTH-1:0];
  endfunction

  logic [CNT_WIDTH-1:0] byte_cnt_q [FLOW_CNT];
  logic [CNT_WIDTH-1:0] byte_cnt_d [FLOW_CNT];
  logic [CNT_WIDTH-1:0] total_q, total_d;
  logic [CNT_WIDTH-1:0] tick_q, tick_d;
  logic [CNT_WIDTH-1:0] rd_bytes_q, rd_bytes_d;

  logic [31:0]       cur_bytes;
  logic [31:0]       emp_clamp;
  logic              hit;
  logic [FLOW_W-1:0] flow_idx;
  logic              unused_ok;

  assign unused_ok = ^{pkt.data, pkt.sop, pkt.flow_num};

  always_comb begin
    emp_clamp = 32'(pkt.empty);
    if (emp_clamp > 32'(BEAT_BYTES)) emp_clamp = 32'(BEAT_BYTES);
    cur_bytes = '0;
    if (pkt.val) begin
      if (pkt.eop) cur_bytes = 32'(BEAT_BYTES) - emp_clamp + 32'd24;
      else         cur_bytes = 32'(BEAT_BYTES);
    end
    hit      = pkt.val && (pkt.flow_num < 32'(FLOW_CNT));
    flow_idx = pkt.flow_num[FLOW_W-1:0];
  end

  // A clear in the same cycle as a beat restarts every counter from that beat.
  always_comb begin
    for (int i = 0; i < FLOW_CNT; i++) begin
      byte_cnt_d[i] = clr ? '0 : byte_cnt_q[i];
      if (hit && flow_idx == FLOW_W'(i)) byte_cnt_d[i] = cnt_add(byte_cnt_d[i], cur_bytes);
    end
    total_d = cnt_add(clr ? '0 : total_q, hit ? cur_bytes : 32'd0);
    tick_d  = cnt_add(clr ? '0 : tick_q, 32'd1);
    rd_bytes_d = '0;
    if (32'(rd_flow) < 32'(FLOW_CNT)) rd_bytes_d = byte_cnt_q[rd_flow];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '{default: '0};
      total_q    <= '0;
      tick_q     <= '0;
      rd_bytes_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      total_q    <= total_d;
      tick_q     <= tick_d;
      rd_bytes_q <= rd_bytes_d;
    end
  end

  assign rd_bytes    = rd_bytes_q;
  assign tick_cnt    = tick_q;
  assign total_bytes = total_q;

endmodule

// File: tb/tb_pkt_modport.sv
// Bench for pkt_modport: single-beat vector table, hand-written multi-cycle sequences,
// and randomized traffic compared against a byte-count model.
module tb_pkt_modport;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pkt_modport_if #(.D_WIDTH(64), .EMPTY_WIDTH(3)) bus ();
  pkt_modport_if #(.D_WIDTH(64), .EMPTY_WIDTH(3)) sbus ();

  logic        clr, s_clr;
  logic [3:0]  rd_flow, s_rd_flow;
  logic [63:0] rd_bytes, tick_cnt, total_bytes;
  logic [7:0]  s_rd_bytes, s_tick_cnt, s_total_bytes;

  pkt_modport u_dut (
    .clk(clk), .rst(rst), .pkt(bus), .clr(clr), .rd_flow(rd_flow),
    .rd_bytes(rd_bytes), .tick_cnt(tick_cnt), .total_bytes(total_bytes)
  );

  pkt_modport #(.CNT_WIDTH(8)) u_small (
    .clk(clk), .rst(rst), .pkt(sbus), .clr(s_clr), .rd_flow(s_rd_flow),
    .rd_bytes(s_rd_bytes), .tick_cnt(s_tick_cnt), .total_bytes(s_total_bytes)
  );

  int n_vec = 0;
  int n_err = 0;

  longint unsigned m_bytes [16];
  longint unsigned m_total = 0, m_tick = 0, m_rd = 0;

  typedef struct {
    logic            val;
    logic            eop;
    logic [2:0]      empty;
    logic [31:0]     flow;
    longint unsigned exp_total;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // L1 bytes a beat contributes on a 64-bit bus.
  function automatic longint unsigned beat_bytes(input logic v, input logic e, input logic [2:0] emp);
    longint unsigned eff;
    if (!v) return 0;
    if (!e) return 8;
    eff = (emp > 3'd0 && 64'(emp) > 8) ? 8 : 64'(emp);
    return 8 - eff + 24;
  endfunction

  task automatic drive(input logic v, input logic e, input logic [2:0] emp, input logic [31:0] f,
                       input logic c);
    bus.val = v; bus.eop = e; bus.empty = emp; bus.flow_num = f; clr = c;
    bus.sop = 1'b0; bus.data = {$urandom, $urandom};
  endtask

  // Advance one clock edge and move the model with it.
  task automatic step();
    longint unsigned cur, prev_rd;
    logic hit, c;
    int f;
    cur     = beat_bytes(bus.val, bus.eop, bus.empty);
    hit     = bus.val && (bus.flow_num < 16);
    f       = int'(bus.flow_num & 32'hF);
    prev_rd = m_bytes[rd_flow];
    c       = clr;
    @(posedge clk);
    #1;
    if (rst) begin
      foreach (m_bytes[i]) m_bytes[i] = 0;
      m_total = 0; m_tick = 0; m_rd = 0;
    end else begin
      if (c) begin
        foreach (m_bytes[i]) m_bytes[i] = 0;
        m_total = 0; m_tick = 0;
      end
      m_tick++;
      if (hit) begin
        m_bytes[f] += cur;
        m_total    += cur;
      end
      m_rd = prev_rd;
    end
  endtask

  initial begin
    foreach (m_bytes[i]) m_bytes[i] = 0;
    vt[0] = '{1'b1, 1'b0, 3'd0, 32'd3,  64'd8};
    vt[1] = '{1'b1, 1'b1, 3'd0, 32'd3,  64'd32};
    vt[2] = '{1'b1, 1'b1, 3'd3, 32'd5,  64'd29};
    vt[3] = '{1'b1, 1'b1, 3'd7, 32'd0,  64'd25};
    vt[4] = '{1'b0, 1'b1, 3'd0, 32'd2,  64'd0};
    vt[5] = '{1'b1, 1'b1, 3'd0, 32'd16, 64'd0};
    vt[6] = '{1'b1, 1'b0, 3'd5, 32'd15, 64'd8};
    vt[7] = '{1'b1, 1'b1, 3'd1, 32'd9,  64'd31};

    drive(1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    rd_flow = 4'd0;
    sbus.val = 1'b0; sbus.eop = 1'b0; sbus.empty = 3'd0; sbus.flow_num = 32'd0;
    sbus.sop = 1'b0; sbus.data = '0;
    s_clr = 1'b0; s_rd_flow = 4'd1;

    #2;
    chk("reset_rd_bytes", rd_bytes, 0);
    chk("reset_tick", tick_cnt, 0);
    chk("reset_total", total_bytes, 0);
    chk("reset_small_tick", 64'(s_tick_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("first_tick_after_reset", tick_cnt, 1);

    // Each vector carries a beat together with clr, so total equals exactly that beat.
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].val, vt[i].eop, vt[i].empty, vt[i].flow, 1'b1);
      step();
      chk($sformatf("vec%0d_total", i), total_bytes, vt[i].exp_total);
      chk($sformatf("vec%0d_tick", i), tick_cnt, 1);
    end

    // Three-beat packet on flow 2, empty=3 on the last beat.
    drive(1'b0, 1'b0, 3'd0, 32'd0, 1'b1); step();
    drive(1'b1, 1'b0, 3'd3, 32'd2, 1'b0); bus.sop = 1'b1; step();
    drive(1'b1, 1'b0, 3'd3, 32'd2, 1'b0); step();
    drive(1'b1, 1'b1, 3'd3, 32'd2, 1'b0); step();
    drive(1'b0, 1'b0, 3'd0, 32'd0, 1'b0); rd_flow = 4'd2; step();
    chk("pkt3_total", total_bytes, 45);
    chk("pkt3_flow2", rd_bytes, 45);
    rd_flow = 4'd1; step();
    chk("pkt3_flow1", rd_bytes, 0);

    // Interleaved single-beat packets on flows 0 and 15.
    drive(1'b0, 1'b0, 3'd0, 32'd0, 1'b1); step();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 3'd0, (i % 2 == 0) ? 32'd0 : 32'd15, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 3'd0, 32'd0, 1'b0); rd_flow = 4'd0; step();
    chk("ilv_flow0", rd_bytes, 320);
    rd_flow = 4'd15; step();
    chk("ilv_flow15", rd_bytes, 320);
    chk("ilv_total", total_bytes, 640);

    // Out-of-range flow: counters hold, tick still moves.
    drive(1'b1, 1'b1, 3'd0, 32'd16, 1'b0); step();
    chk("oor_total", total_bytes, 640);
    chk("oor_tick", tick_cnt, m_tick);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 1'b0); step();
    chk("oor_flow15", rd_bytes, 320);

    // 8-bit counters: 9 beats of 32 bytes overflow a 256 range.
    sbus.flow_num = 32'd1; sbus.eop = 1'b1; sbus.empty = 3'd0;
    for (int i = 0; i < 9; i++) begin
      sbus.val = 1'b1;
      step();
    end
    sbus.val = 1'b0;
    step();
`ifdef PKT_MODPORT_SAT_EN
    chk("small_total_sat", 64'(s_total_bytes), 255);
    chk("small_flow1_sat", 64'(s_rd_bytes), 255);
`else
    chk("small_total_wrap", 64'(s_total_bytes), 32);
    chk("small_flow1_wrap", 64'(s_rd_bytes), 32);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
            32'($urandom_range(0, 17)), $urandom_range(0, 39) == 0);
      bus.sop = 1'($urandom);
      rd_flow = 4'($urandom_range(0, 15));
      step();
      chk("rand_tick", tick_cnt, m_tick);
      chk("rand_total", total_bytes, m_total);
      chk("rand_rd_bytes", rd_bytes, m_rd);
    end

    // Reset raised between edges, partway through a packet.
    drive(1'b1, 1'b0, 3'd0, 32'd4, 1'b0); step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tick", tick_cnt, 0);
    chk("async_rst_total", total_bytes, 0);
    chk("async_rst_rd", rd_bytes, 0);
    foreach (m_bytes[i]) m_bytes[i] = 0;
    m_total = 0; m_tick = 0; m_rd = 0;
    #1 rst = 1'b0;
    drive(1'b1, 1'b1, 3'd2, 32'd4, 1'b0); step();
    chk("post_rst_tick", tick_cnt, 1);
    chk("post_rst_total", total_bytes, 30);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 1'b0); rd_flow = 4'd4; step();
    chk("post_rst_flow4", rd_bytes, 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
